// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw pins and enable in, settled vector and edge pulses out.
// The debouncer is the slave; whoever supplies pins and enable is the master.
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 15
);
  logic             EN;
  logic [WIDTH-1:0] SW_RAW;
  logic [WIDTH-1:0] SW_OUT;
  logic             SW_CHANGED;
  logic [WIDTH-1:0] SW_RISE;
  logic [WIDTH-1:0] SW_FALL;

  modport master (
    output EN,
    output SW_RAW,
    input  SW_OUT,
    input  SW_CHANGED,
    input  SW_RISE,
    input  SW_FALL
  );

  modport slave (
    input  EN,
    input  SW_RAW,
    output SW_OUT,
    output SW_CHANGED,
    output SW_RISE,
    output SW_FALL
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit synchroniser and tick-sampled debouncer feeding the AHB switch-input SWITCH bus.
// A bit accepts a new level only after STABLE_TICKS consecutive ticks of mismatch.
module switch_debouncer #(
  parameter int unsigned WIDTH        = 15,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input logic              HCLK,
  input logic              HRESET,
  switch_debouncer_if.slave sw
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CntMax   = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_w;

  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic [WIDTH-1:0]        rise_q, rise_d;
  logic [WIDTH-1:0]        fall_q, fall_d;
  logic                    changed_q, changed_d;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Synchroniser keeps sampling regardless of EN.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sw.SW_RAW;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_comb begin
    tick    = sw.EN && (presc_q == PrescMax);
    presc_d = presc_q;
    if (sw.EN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_w[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          out_d[i]  = sync_w[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_w[i];
          fall_d[i] = ~sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw.SW_OUT     = out_q;
  assign sw.SW_RISE    = rise_q;
  assign sw.SW_FALL    = fall_q;
  assign sw.SW_CHANGED = changed_q;

endmodule
